// File: rtl/vtisa_pkg.sv
// Shared constants and types for the vtisa core front end.
// Define FETCH_PREFETCH_EN for a two-entry fetch buffer (one byte of lookahead).
package vtisa_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int INSTR_W        = 8;

`ifdef FETCH_PREFETCH_EN
   localparam int FETCH_DEPTH = 2;
`else
   localparam int FETCH_DEPTH = 1;
`endif

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN
   } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Small {instr, pc} FIFO feeding the decoder; entry 0 is always the head.
// Flush beats push; a push into a full buffer is accepted only alongside a pop.
module fetch_buf
   import vtisa_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 8,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic [ADDR_W-1:0]  push_pc,
   output logic [INSTR_W-1:0] head_instr,
   output logic [ADDR_W-1:0]  head_pc,
   output logic [CNT_W-1:0]   count
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [INSTR_W-1:0] instr_q [DEPTH];
   logic [ADDR_W-1:0]  pc_q    [DEPTH];
   logic               do_push;
   logic               do_pop;
   logic [IDX_W-1:0]   wr_idx;

   always_comb begin
      do_pop  = pop && (count != '0);
      do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
      // Write slot accounts for the shift-down caused by a simultaneous pop.
      wr_idx  = IDX_W'(count - CNT_W'(do_pop));
   end

   // NOTE: storage is reset too, so instr/instr_pc read 0 after reset rather than X.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else if (flush) begin
         count <= '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               instr_q[i] <= instr_q[i+1];
               pc_q[i]    <= pc_q[i+1];
            end
         end
         if (do_push) begin
            instr_q[wr_idx] <= push_instr;
            pc_q[wr_idx]    <= push_pc;
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   assign head_instr = instr_q[0];
   assign head_pc    = pc_q[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, reads bytes from instruction memory
// over req/ack and hands them to the decoder. Buffer depth set by FETCH_PREFETCH_EN.
module instr_fetch
   import vtisa_pkg::*;
#(
   parameter int                ADDR_W   = ADDR_W_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc
);

   localparam int CNT_W = $clog2(FETCH_DEPTH + 1);

   fetch_state_e      state, state_nxt;
   logic [ADDR_W-1:0] fpc, fpc_nxt;
   logic              issue;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count;
   logic [CNT_W:0]    occupancy;

   // An outstanding (non-stale) request reserves a buffer slot.
   assign occupancy = {1'b0, count} + (CNT_W+1)'(state == REQ);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      fpc_nxt   = fpc;
      issue     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!redirect && (occupancy < (CNT_W+1)'(FETCH_DEPTH))) begin
               issue     = 1'b1;
               state_nxt = REQ;
               fpc_nxt   = fpc + ADDR_W'(1);
            end
         end
         REQ: begin
            if (mem_ack)       state_nxt = IDLE;
            else if (redirect) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (mem_ack) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (redirect) fpc_nxt = redirect_pc;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fpc      <= RESET_PC;
         mem_addr <= '0;
      end else begin
         state <= state_nxt;
         fpc   <= fpc_nxt;
         if (issue) mem_addr <= fpc;
      end
   end

   assign mem_req     = (state != IDLE);
   assign push        = (state == REQ) && mem_ack && !redirect;
   assign pop         = instr_valid && instr_ready && !redirect;
   assign instr_valid = (count != '0);

   fetch_buf #(
      .DEPTH  (FETCH_DEPTH),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (redirect),
      .push_instr (mem_rdata),
      .push_pc    (mem_addr),
      .head_instr (instr),
      .head_pc    (instr_pc),
      .count      (count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order fetch, decoder stall, redirects, PC wrap
// and reset mid-request. Expectations follow FETCH_PREFETCH_EN when it is defined.
module tb_instr_fetch;

   logic       clk;
   logic       reset;
   logic       mem_req, mem_ack, instr_valid, instr_ready, redirect;
   logic [7:0] mem_addr, mem_rdata, instr, instr_pc, redirect_pc;

   logic       mem_req2, mem_ack2, instr_valid2;
   logic [7:0] mem_addr2, mem_rdata2, instr2, instr_pc2;
   logic       instr_ready2 = 1'b1;
   logic       redirect2 = 1'b0;
   logic [7:0] redirect_pc2 = 8'h00;

   int passed = 0;
   int total  = 0;

   instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
      .clk (clk), .reset (reset),
      .mem_req (mem_req), .mem_addr (mem_addr), .mem_ack (mem_ack), .mem_rdata (mem_rdata),
      .instr (instr), .instr_pc (instr_pc), .instr_valid (instr_valid), .instr_ready (instr_ready),
      .redirect (redirect), .redirect_pc (redirect_pc)
   );

   instr_fetch #(.ADDR_W(8), .RESET_PC(8'hFE)) dut_wrap (
      .clk (clk), .reset (reset),
      .mem_req (mem_req2), .mem_addr (mem_addr2), .mem_ack (mem_ack2), .mem_rdata (mem_rdata2),
      .instr (instr2), .instr_pc (instr_pc2), .instr_valid (instr_valid2), .instr_ready (instr_ready2),
      .redirect (redirect2), .redirect_pc (redirect_pc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},   32'(mem_req),     32'd0);
      chk({tag, "_addr"},  32'(mem_addr),    32'd0);
      chk({tag, "_instr"}, 32'(instr),       32'd0);
      chk({tag, "_pc"},    32'(instr_pc),    32'd0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
   endtask

   // Bounded wait for a request on the main DUT, then check its address.
   task automatic wait_req(input logic [7:0] exp_addr, input string tag);
      int n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk({tag, "_req"},  32'(mem_req),  32'd1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
   endtask

   // Hold the request one cycle, ack it, then check the registered result.
   task automatic serve(input logic [7:0] addr, input logic [7:0] data, input string tag);
      step();
      chk({tag, "_stable"}, 32'(mem_addr), 32'(addr));
      mem_ack   = 1'b1;
      mem_rdata = data;
      step();
      mem_ack   = 1'b0;
      chk({tag, "_idle"},  32'(mem_req),     32'd0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
   endtask

   initial begin
      logic [7:0] bytes [3];
      logic [7:0] wrap_addr [3];
      int         req_seen;

      bytes     = '{8'h11, 8'h22, 8'h33};
      wrap_addr = '{8'hFE, 8'hFF, 8'h00};
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = 8'h00;
      instr_ready = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 8'h00;
      mem_ack2    = 1'b0;
      mem_rdata2  = 8'h00;

      step();
      step();
      chk_reset_vals("rst");

      // First cycle after release decides; request appears in the second.
      reset = 1'b0;
      chk("first_cycle_req", 32'(mem_req), 32'd0);
      step();
      chk("second_cycle_req",  32'(mem_req),  32'd1);
      chk("second_cycle_addr", 32'(mem_addr), 32'h00);

      for (int k = 0; k < 3; k++) begin
         wait_req(8'(k), $sformatf("seq%0d", k));
         serve(8'(k), bytes[k], $sformatf("seq%0d", k));
         chk($sformatf("seq%0d_instr", k), 32'(instr),    32'(bytes[k]));
         chk($sformatf("seq%0d_pc", k),    32'(instr_pc), 32'(k));
      end
      step();

      // Decoder stall.
      instr_ready = 1'b0;
      wait_req(8'h03, "stall_a");
      serve(8'h03, 8'h44, "stall_a");
`ifdef FETCH_PREFETCH_EN
      wait_req(8'h04, "stall_b");
      serve(8'h04, 8'h55, "stall_b");
`endif
      chk("stall_head_instr", 32'(instr),    32'h44);
      chk("stall_head_pc",    32'(instr_pc), 32'h03);
      req_seen = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (mem_req === 1'b1) req_seen++;
      end
      chk("stall_no_extra_req", 32'(req_seen), 32'd0);
      chk("stall_valid_held",   32'(instr_valid), 32'd1);
      chk("stall_instr_held",   32'(instr), 32'h44);

      instr_ready = 1'b1;
      step();
`ifdef FETCH_PREFETCH_EN
      chk("lookahead_valid", 32'(instr_valid), 32'd1);
      chk("lookahead_instr", 32'(instr),       32'h55);
      chk("lookahead_pc",    32'(instr_pc),    32'h04);
      step();
`else
      chk("single_popped", 32'(instr_valid), 32'd0);
      wait_req(8'h04, "resume");
      serve(8'h04, 8'h55, "resume");
      chk("resume_instr", 32'(instr), 32'h55);
`endif

      // Redirect while the request for 0x05 is outstanding.
      wait_req(8'h05, "redir");
      redirect    = 1'b1;
      redirect_pc = 8'h40;
      step();
      redirect = 1'b0;
      chk("drain_req",   32'(mem_req),     32'd1);
      chk("drain_addr",  32'(mem_addr),    32'h05);
      chk("drain_valid", 32'(instr_valid), 32'd0);
      step();
      chk("drain_addr_hold", 32'(mem_addr), 32'h05);
      mem_ack   = 1'b1;
      mem_rdata = 8'hEE;
      step();
      mem_ack = 1'b0;
      chk("drain_ack_dropped", 32'(instr_valid), 32'd0);
      chk("drain_ack_idle",    32'(mem_req),     32'd0);
      step();
      chk("redir_target_req",  32'(mem_req),     32'd1);
      chk("redir_target_addr", 32'(mem_addr),    32'h40);
      chk("redir_still_empty", 32'(instr_valid), 32'd0);

      // Redirect in the same cycle as mem_ack and instr_ready.
      step();
      mem_ack     = 1'b1;
      mem_rdata   = 8'h77;
      instr_ready = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 8'h80;
      step();
      mem_ack  = 1'b0;
      redirect = 1'b0;
      chk("same_cycle_dropped", 32'(instr_valid), 32'd0);
      chk("same_cycle_idle",    32'(mem_req),     32'd0);
      step();
      chk("same_cycle_req",   32'(mem_req),     32'd1);
      chk("same_cycle_addr",  32'(mem_addr),    32'h80);
      chk("same_cycle_empty", 32'(instr_valid), 32'd0);

      // Reset while a request is outstanding; a late ack must be ignored.
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_reset_vals("midrst");
      mem_ack   = 1'b1;
      mem_rdata = 8'h99;
      step();
      mem_ack = 1'b0;
      chk("late_ack_valid", 32'(instr_valid), 32'd0);
      chk("late_ack_req",   32'(mem_req),     32'd1);
      chk("late_ack_addr",  32'(mem_addr),    32'h00);
      step();
      chk("late_ack_valid2", 32'(instr_valid), 32'd0);

      // PC wrap from RESET_PC=0xFE on the second instance.
      for (int k = 0; k < 3; k++) begin
         int n = 0;
         while (mem_req2 !== 1'b1 && n < 8) begin
            step();
            n++;
         end
         chk($sformatf("wrap%0d_req", k),  32'(mem_req2),  32'd1);
         chk($sformatf("wrap%0d_addr", k), 32'(mem_addr2), 32'(wrap_addr[k]));
         step();
         mem_ack2   = 1'b1;
         mem_rdata2 = 8'hA0 + 8'(k);
         step();
         mem_ack2 = 1'b0;
         chk($sformatf("wrap%0d_valid", k), 32'(instr_valid2), 32'd1);
         chk($sformatf("wrap%0d_pc", k),    32'(instr_pc2),    32'(wrap_addr[k]));
         chk($sformatf("wrap%0d_instr", k), 32'(instr2),       32'(8'hA0 + 8'(k)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
